// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and lane helpers for the simple-dual-port SRAM
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_e;

    localparam int BYTE_W = 8;

    function automatic int num_lanes(input int data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/sram_sdp_clear.sv
// rtl/sram_sdp_clear.sv - post-reset clear sequencer: walks every address once, then holds READY
module sram_sdp_clear
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    sram_state_e           state;
    logic [ADDR_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            count <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (count == LAST) begin
                        state <= READY;
                        busy  <= 1'b0;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= CLEAR;
                    count <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign clr_addr = count;

endmodule

// File: rtl/sram_sdp.sv
// rtl/sram_sdp.sv - simple-dual-port SRAM, byte-lane writes, write-first bypass, hardware clear
// Optional: SRAM_SDP_OUT_REG_EN adds a second read output stage (latency 2).
module sram_sdp
    import sram_pkg::*;
#(
    parameter int                      ADDR_WIDTH = 8,
    parameter int                      DATA_WIDTH = 32,
    parameter int                      DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0]   INIT_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      busy,
    output logic                      err
);

    localparam int LANES = num_lanes(DATA_WIDTH);
    localparam int IW    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
        $error("sram_sdp: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH < 2 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("sram_sdp: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         clr_addr;
    logic                  wr_ok, rd_ok, wr_go, rd_go, hit;
    logic [IW-1:0]         wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data_s1;
    logic                  rd_valid_s1;

    sram_sdp_clear #(
        .ADDR_WIDTH (IW),
        .DEPTH      (DEPTH)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_addr (clr_addr)
    );

    assign wr_ok  = {1'b0, wr_addr} < DEPTH_L;
    assign rd_ok  = {1'b0, rd_addr} < DEPTH_L;
    assign wr_idx = wr_addr[IW-1:0];
    assign rd_idx = rd_addr[IW-1:0];
    assign wr_go  = !busy && wr_en && wr_ok;
    assign rd_go  = !busy && rd_en;
    assign hit    = wr_go && (wr_addr == rd_addr);

    // Write-first: enabled lanes of a same-address write bypass the array.
    always_comb begin
        rd_word = mem[rd_idx];
        for (int i = 0; i < LANES; i++) begin
            if (hit && wr_be[i]) begin
                rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem[clr_addr] <= INIT_VALUE;
            end else if (wr_go) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wr_be[i]) begin
                        mem[wr_idx][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_s1  <= '0;
            rd_valid_s1 <= 1'b0;
            err         <= 1'b0;
        end else begin
            rd_valid_s1 <= rd_go;
            if (rd_go) begin
                rd_data_s1 <= rd_ok ? rd_word : '0;
            end
            if (!busy && ((wr_en && !wr_ok) || (rd_en && !rd_ok))) begin
                err <= 1'b1;
            end
        end
    end

`ifdef SRAM_SDP_OUT_REG_EN
    logic [DATA_WIDTH-1:0] rd_data_s2;
    logic                  rd_valid_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_s2  <= '0;
            rd_valid_s2 <= 1'b0;
        end else begin
            rd_data_s2  <= rd_data_s1;
            rd_valid_s2 <= rd_valid_s1;
        end
    end

    assign rd_data  = rd_data_s2;
    assign rd_valid = rd_valid_s2;
`else
    assign rd_data  = rd_data_s1;
    assign rd_valid = rd_valid_s1;
`endif

endmodule

// File: tb/tb_sram_sdp.sv
// tb/tb_sram_sdp.sv - randomized scoreboard bench for sram_sdp (DEPTH=200, INIT=A5A5A5A5)
module tb_sram_sdp;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 200;
    localparam logic [DW-1:0] INIT = 32'hA5A5A5A5;
`ifdef SRAM_SDP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          err;

    sram_sdp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .INIT_VALUE (INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic [DW-1:0] model [DEPTH];
    exp_t          q [$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            busy_exp = 1'b1;
    bit            err_exp = 1'b0;
    logic [DW-1:0] last_exp = '0;
    int            clr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the reference model decides what must come back.
    task automatic step(input bit r, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [3:0] be, input bit re, input logic [AW-1:0] ra);
        exp_t e;
        logic [DW-1:0] v;
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
        if (!r && !busy_exp) begin
            if (re) begin
                v = '0;
                if (ra < DEPTH) begin
                    v = model[ra];
                    if (we && wa == ra)
                        for (int i = 0; i < 4; i++) if (be[i]) v[i*8 +: 8] = wd[i*8 +: 8];
                end
                e.data = v;
                e.due  = cyc + LAT;
                q.push_back(e);
            end
            if (we && wa < DEPTH)
                for (int i = 0; i < 4; i++) if (be[i]) model[wa][i*8 +: 8] = wd[i*8 +: 8];
        end
        @(posedge clk);
        #1;
        if (r) begin
            busy_exp = 1'b1; clr_cnt = 0; err_exp = 1'b0; last_exp = '0; q.delete();
        end else if (busy_exp) begin
            clr_cnt++;
            if (clr_cnt == DEPTH) begin
                busy_exp = 1'b0;
                for (int a = 0; a < DEPTH; a++) model[a] = INIT;
            end
        end else if ((we && wa >= DEPTH) || (re && ra >= DEPTH)) begin
            err_exp = 1'b1;
        end
    endtask

    function automatic logic [AW-1:0] rand_addr(input int oob_pct);
        if (int'($urandom_range(99)) < oob_pct) return AW'($urandom_range(255, DEPTH));
        return AW'($urandom_range(DEPTH - 1));
    endfunction

    task automatic rand_step(input int oob_pct);
        logic [AW-1:0] wa, ra;
        wa = rand_addr(oob_pct);
        ra = ($urandom_range(99) < 30) ? wa : rand_addr(oob_pct);
        step(1'b0, 1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom), ra);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("busy", {31'b0, busy}, {31'b0, busy_exp});
        chk("err", {31'b0, err}, {31'b0, err_exp});
        if (rd_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rd_valid actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("rd_data", rd_data, e.data);
                chk("rd_latency", cyc, e.due);
                last_exp = e.data;
            end
        end else begin
            chk("rd_hold", rd_data, last_exp);
            if (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++; errors++;
                $display("FAIL missing_rd_valid actual=0 expected=1 (due cycle %0d)", e.due);
            end
        end
    end

    initial begin
        step(1'b1, 1'b1, 8'd1, 32'h1, 4'hF, 1'b1, 8'd1);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 8'd2);
        chk("reset_rd_data", rd_data, '0);
        chk("reset_rd_valid", {31'b0, rd_valid}, '0);
        chk("reset_busy", {31'b0, busy}, 32'd1);
        chk("reset_err", {31'b0, err}, '0);

        // Abort the clear after nine addresses, then run a full clear with noise on the ports.
        repeat (9) rand_step(20);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        repeat (DEPTH - 1) rand_step(20);
        chk("busy_last_clear_cycle", {31'b0, busy}, 32'd1);
        rand_step(20);
        chk("busy_after_clear", {31'b0, busy}, '0);
        chk("err_after_clear", {31'b0, err}, '0);

        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(i));
        repeat (LAT) idle();

        step(1'b0, 1'b1, 8'd3, 32'h11223344, 4'b0101, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'd3);
        repeat (LAT - 1) idle();
        chk("byte_lane_write", rd_data, 32'hA522A544);
        chk("byte_lane_valid", {31'b0, rd_valid}, 32'd1);

        step(1'b0, 1'b1, 8'd7, 32'hDEADBEEF, 4'b1111, 1'b1, 8'd7);
        repeat (LAT - 1) idle();
        chk("collision_data", rd_data, 32'hDEADBEEF);
        chk("collision_valid", {31'b0, rd_valid}, 32'd1);

        step(1'b0, 1'b1, 8'd250, 32'h12345678, 4'hF, 1'b1, 8'd230);
        repeat (LAT - 1) idle();
        chk("oob_rd_data", rd_data, '0);
        chk("oob_rd_valid", {31'b0, rd_valid}, 32'd1);
        chk("oob_err", {31'b0, err}, 32'd1);

        repeat (600) rand_step(5);
        repeat (LAT + 1) idle();
        chk("scoreboard_drained", q.size(), '0);

        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        chk("final_reset_err", {31'b0, err}, '0);
        chk("final_reset_busy", {31'b0, busy}, 32'd1);
        chk("final_reset_rd_data", rd_data, '0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_sdp.md
# sram_sdp

Parametrised simple-dual-port synchronous SRAM: one write port and one read port per cycle, byte-lane write enables, write-first collision handling and a hardware clear sequencer that fills the array after reset. Sits beside the single-port `ram` as the general on-chip storage primitive for FIFOs, packet buffers and register files.

## Interface

- `ADDR_WIDTH`, 8: address bits.
- `DATA_WIDTH`, 32: word bits; must be a multiple of 8 (elaboration error otherwise).
- `DEPTH`, 256: number of words; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_WIDTH (elaboration error otherwise).
- `INIT_VALUE`, 0: `DATA_WIDTH`-bit word written to every location by the clear sequence.

Ports:

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write request.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `wr_be`  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- `rd_en`  in  1  read request.
- `rd_addr`  in  ADDR_WIDTH  read address.
- `rd_data`  out  DATA_WIDTH  registered read data.
- `rd_valid`  out  1  one-cycle strobe qualifying `rd_data`.
- `busy`  out  1  clear sequence in progress; requests ignored.
- `err`  out  1  sticky out-of-range access flag.

## Operation

- Reset values: `rd_data`=0, `rd_valid`=0, `busy`=1, `err`=0, clear counter=0, state CLEAR.
- FSM states: CLEAR, READY.
  - CLEAR: each non-reset edge writes `INIT_VALUE` to mem[counter], counter increments; the edge writing DEPTH-1 moves to READY.
  - READY: normal access; leaves only on `rst`.
  - `rst` in any state, including mid-clear, restarts CLEAR at address 0.
- While `busy`=1: `wr_en`/`rd_en` ignored, no `err` update, `rd_valid`=0.
- Write (READY, `wr_en`=1, `wr_addr` < DEPTH): lanes with `wr_be`[i]=1 updated; others unchanged. `wr_be`=0 is a legal no-op.
- Read (READY, `rd_en`=1, `rd_addr` < DEPTH): `rd_data` gets mem[`rd_addr`], `rd_valid` pulses.
- Collision (read and write same in-range address same cycle): write-first; per lane, enabled lanes return `wr_data`, others return old contents.
- Out-of-range write: dropped, `err` set. Out-of-range read: `rd_data`=0, `rd_valid` still pulses, `err` set. `err` clears only on `rst`.
- `rd_data` holds its last value when `rd_valid`=0.

## Timing

- Clear duration: `busy` falls after exactly DEPTH edges with `rst` low; first request accepted on the edge where `busy` is sampled 0.
- Read latency: 1 cycle (request edge N → `rd_data`/`rd_valid` after edge N+1's... i.e. valid in cycle N+1); 2 cycles with output register.
- Throughput: one read and one write every cycle, no stalls in READY.
- Write visible to a read issued in the same cycle (bypass) and in every later cycle.
- `err` asserts the cycle after the offending request.

## Configuration

- `SRAM_SDP_OUT_REG_EN` defined: extra pipeline register on `rd_data`, `rd_valid`, out-of-range zeroing; read latency 2; reset clears both stages; `rd_valid` never asserts for requests issued during CLEAR.
- Undefined: single output stage, latency 1.

## Structure

- Package `sram_pkg`: `sram_state_e` enum (CLEAR, READY), byte-lane width constant 8, function computing `DATA_WIDTH/8`.
- Sub-module `sram_sdp_clear`: CLEAR/READY FSM and counter, emits clear write enable/address and `busy`; top merges it onto the write port.

## Test plan

- Reset with DEPTH=16, INIT_VALUE=32'hA5A5A5A5 -> `busy` high 16 cycles; reads of addresses 0..15 return 32'hA5A5A5A5; `err`=0.
- Write 32'h11223344 to address 3, `wr_be`=4'b0101, old content 32'hA5A5A5A5 -> read returns 32'hA522A544 after 1 cycle (2 with macro).
- Same-cycle write 32'hDEADBEEF `wr_be`=4'b1111 and read to address 7 -> `rd_data`=32'hDEADBEEF, `rd_valid`=1 next cycle.
- DEPTH=200, ADDR_WIDTH=8: write to 250 and read from 230 -> no memory change, `rd_data`=0 with `rd_valid`=1, `err`=1 until `rst`.
- `rst` asserted at clear count 9 -> `busy` stays high a further DEPTH cycles; requests during CLEAR produce no `rd_valid`.
- Back-to-back reads of addresses 0..15 every cycle -> 16 consecutive `rd_valid` pulses, data in request order.
